// File: rtl/symbol_splitter_pkg.sv
// Shared PSK definitions for the splitter and the modulator: default symbol width,
// legal-width check and the Gray encoder.
package symbol_splitter_pkg;

  localparam int PSK_BITS_PER_SYMBOL = 4;

  function automatic bit psk_bps_legal(input int bps);
    return (bps == 1) || (bps == 2) || (bps == 4) || (bps == 8);
  endfunction

  function automatic logic [7:0] psk_gray8(input logic [7:0] s);
    return s ^ (s >> 1);
  endfunction

endpackage

// File: rtl/symbol_gray_map.sv
// Combinational binary-to-Gray symbol map, only built with SYMBOL_SPLITTER_GRAY_EN
// (the default build needs no mapping and so carries no extra module).
`ifdef SYMBOL_SPLITTER_GRAY_EN
module symbol_gray_map #(
  parameter int W = 4
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] code
);

  assign code = bin ^ (bin >> 1);

endmodule
`endif

// File: rtl/symbol_splitter.sv
// Byte-to-symbol adapter feeding the PSK modulator, with a one-byte prefetch.
// Optional macro SYMBOL_SPLITTER_GRAY_EN: Gray-code each symbol before it reaches sample.
module symbol_splitter
  import symbol_splitter_pkg::*;
#(
  parameter int BITS_PER_SYMBOL = PSK_BITS_PER_SYMBOL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_empty,
  output logic       in_read,
  output logic [7:0] sample,
  output logic       empty,
  input  logic       read,
  output logic       underrun
);

  localparam int         SYMBOLS_PER_BYTE = 8 / BITS_PER_SYMBOL;
  localparam logic [3:0] SPB              = 4'(SYMBOLS_PER_BYTE);

  if (!psk_bps_legal(BITS_PER_SYMBOL)) begin : g_bad_bps
    $error("symbol_splitter: BITS_PER_SYMBOL must be 1, 2, 4 or 8");
  end

  logic [7:0] sreg_r;
  logic [3:0] cnt_r;
  logic [7:0] nbuf_r;
  logic       nvalid_r;
  logic       pend_r;
  logic       in_read_r;
  logic [7:0] sample_r;
  logic       underrun_r;

  logic                       fetch_s;
  logic [BITS_PER_SYMBOL-1:0] top_s;
  logic [BITS_PER_SYMBOL-1:0] sym_s;
  logic [7:0]                 sample_next_s;

  assign fetch_s = !in_empty && !nvalid_r && !pend_r && !in_read_r;
  assign top_s   = sreg_r[7 -: BITS_PER_SYMBOL];

`ifdef SYMBOL_SPLITTER_GRAY_EN
  symbol_gray_map #(.W(BITS_PER_SYMBOL)) u_gray (
    .bin  (top_s),
    .code (sym_s)
  );
`else
  assign sym_s = top_s;
`endif

  // Zero-extend the sliced symbol into the 8-bit sample word
  always_comb begin
    sample_next_s = 8'h00;
    sample_next_s[BITS_PER_SYMBOL-1:0] = sym_s;
  end

  // Upstream pop: one strobe per byte, never while a byte is buffered or in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_read_r <= 1'b0;
      pend_r    <= 1'b0;
    end else begin
      in_read_r <= fetch_s;
      pend_r    <= fetch_s;
    end
  end

  // Capture, load, slice and underrun; pend and nvalid are never both set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_r     <= 8'h00;
      cnt_r      <= 4'd0;
      nbuf_r     <= 8'h00;
      nvalid_r   <= 1'b0;
      sample_r   <= 8'h00;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= read && (cnt_r == 4'd0);
      if (pend_r) begin
        nbuf_r   <= in_data;
        nvalid_r <= 1'b1;
      end
      if (read && (cnt_r != 4'd0)) begin
        sample_r <= sample_next_s;
        // Last symbol leaving while a byte waits: reload in the same cycle
        if ((cnt_r == 4'd1) && nvalid_r) begin
          sreg_r   <= nbuf_r;
          cnt_r    <= SPB;
          nvalid_r <= 1'b0;
        end else begin
          sreg_r <= sreg_r << BITS_PER_SYMBOL;
          cnt_r  <= cnt_r - 4'd1;
        end
      end else if ((cnt_r == 4'd0) && nvalid_r) begin
        sreg_r   <= nbuf_r;
        cnt_r    <= SPB;
        nvalid_r <= 1'b0;
      end
    end
  end

  assign in_read  = in_read_r;
  assign sample   = sample_r;
  assign empty    = (cnt_r == 4'd0);
  assign underrun = underrun_r;

endmodule

// File: tb/tb_symbol_splitter.sv
// Directed bench for symbol_splitter at 4, 2 and 8 bits per symbol, each instance
// fed by its own show-ahead byte FIFO model.
module tb_symbol_splitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] mem [3][16];
  int         n [3]      = '{0, 0, 0};
  int         idx [3]    = '{0, 0, 0};
  int         rd_cnt [3] = '{0, 0, 0};
  logic [7:0] in_data [3];
  logic       in_empty [3];
  logic       in_read [3];
  logic       read [3];
  logic [7:0] sample [3];
  logic       empty [3];
  logic       underrun [3];

  int checks = 0;
  int errors = 0;

  // Show-ahead upstream FIFO: head visible combinationally, popped on in_read
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      in_empty[k] = (idx[k] >= n[k]);
      in_data[k]  = in_empty[k] ? 8'h00 : mem[k][idx[k][3:0]];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (in_read[k]) begin
        idx[k]    <= idx[k] + 1;
        rd_cnt[k] <= rd_cnt[k] + 1;
      end
    end
  end

  symbol_splitter #(.BITS_PER_SYMBOL(4)) u_bps4 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_empty(in_empty[0]), .in_read(in_read[0]),
    .sample(sample[0]), .empty(empty[0]), .read(read[0]), .underrun(underrun[0]));

  symbol_splitter #(.BITS_PER_SYMBOL(2)) u_bps2 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_empty(in_empty[1]), .in_read(in_read[1]),
    .sample(sample[1]), .empty(empty[1]), .read(read[1]), .underrun(underrun[1]));

  symbol_splitter #(.BITS_PER_SYMBOL(8)) u_bps8 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_empty(in_empty[2]), .in_read(in_read[2]),
    .sample(sample[2]), .empty(empty[2]), .read(read[2]), .underrun(underrun[2]));

  function automatic logic [7:0] enc(input logic [7:0] s);
`ifdef SYMBOL_SPLITTER_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    mem[k][n[k][3:0]] = b;
    n[k] = n[k] + 1;
  endtask

  task automatic wait_ready(input int k, input string tag);
    for (int i = 0; i < 20 && empty[k]; i++) @(negedge clk);
    check(tag, {31'd0, empty[k]}, 32'd0);
  endtask

  // Hold read high across one edge, then check the symbol and empty flag
  task automatic read_step(input int k, input logic [7:0] exp_s, input logic exp_e, input string tag);
    read[k] = 1'b1;
    @(negedge clk);
    check({tag, "_sample"}, {24'd0, sample[k]}, {24'd0, enc(exp_s)});
    check({tag, "_empty"}, {31'd0, empty[k]}, {31'd0, exp_e});
  endtask

  logic [7:0] got [8];
  logic [7:0] exp6 [3];
  int         g;
  logic       take;

  initial begin
    exp6 = '{8'h11, 8'h22, 8'h33};
    g    = 0;
    rst  = 1'b0;
    for (int k = 0; k < 3; k++) read[k] = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_sample%0d", k), {24'd0, sample[k]}, 32'd0);
      check($sformatf("rst_empty%0d", k), {31'd0, empty[k]}, 32'd1);
      check($sformatf("rst_in_read%0d", k), {31'd0, in_read[k]}, 32'd0);
      check($sformatf("rst_underrun%0d", k), {31'd0, underrun[k]}, 32'd0);
    end
    rst = 1'b1;

    // Two bytes, continuous reads once the prefetch is full: no empty gap
    push(0, 8'h3C);
    push(0, 8'h69);
    wait_ready(0, "t1_ready");
    repeat (3) @(negedge clk);
    read_step(0, 8'h03, 1'b0, "t1_s0");
    read_step(0, 8'h0C, 1'b0, "t1_s1");
    read_step(0, 8'h06, 1'b0, "t1_s2");
    read_step(0, 8'h09, 1'b1, "t1_s3");
    read[0] = 1'b0;
    check("t1_in_read_count", rd_cnt[0], 32'd2);

    // Single byte then upstream empty; restart latency
    push(0, 8'hA5);
    wait_ready(0, "t3_ready");
    read_step(0, 8'h0A, 1'b0, "t3_s0");
    read_step(0, 8'h05, 1'b1, "t3_s1");
    read[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("t3_no_pop_count", rd_cnt[0], 32'd3);
    check("t3_in_read_idle", {31'd0, in_read[0]}, 32'd0);
    push(0, 8'h77);
    @(negedge clk);
    check("t3_lat1_empty", {31'd0, empty[0]}, 32'd1);
    @(negedge clk);
    check("t3_lat2_empty", {31'd0, empty[0]}, 32'd1);
    @(negedge clk);
    check("t3_lat3_empty", {31'd0, empty[0]}, 32'd0);

    // Underrun: one extra read after the byte drains
    read_step(0, 8'h07, 1'b0, "t4_s0");
    read_step(0, 8'h07, 1'b1, "t4_s1");
    @(negedge clk);
    read[0] = 1'b0;
    check("t4_underrun", {31'd0, underrun[0]}, 32'd1);
    check("t4_hold_sample", {24'd0, sample[0]}, {24'd0, enc(8'h07)});
    check("t4_hold_empty", {31'd0, empty[0]}, 32'd1);
    @(negedge clk);
    check("t4_underrun_pulse", {31'd0, underrun[0]}, 32'd0);
    check("t4_sample_after", {24'd0, sample[0]}, {24'd0, enc(8'h07)});

    // Reset after the first of two symbols
    push(0, 8'hB4);
    wait_ready(0, "t5_ready");
    read_step(0, 8'h0B, 1'b0, "t5_s0");
    read[0] = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_rst_empty", {31'd0, empty[0]}, 32'd1);
    check("t5_rst_sample", {24'd0, sample[0]}, 32'd0);
    check("t5_rst_in_read", {31'd0, in_read[0]}, 32'd0);
    push(0, 8'hD2);
    @(negedge clk);
    rst = 1'b1;
    wait_ready(0, "t5_ready2");
    read_step(0, 8'h0D, 1'b0, "t5_after0");
    read_step(0, 8'h02, 1'b1, "t5_after1");
    read[0] = 1'b0;

    // Two-bit symbols
    push(1, 8'hE4);
    wait_ready(1, "t2_ready");
    read_step(1, 8'h03, 1'b0, "t2_s0");
    read_step(1, 8'h02, 1'b0, "t2_s1");
    read_step(1, 8'h01, 1'b0, "t2_s2");
    read_step(1, 8'h00, 1'b1, "t2_s3");
    read[1] = 1'b0;

    // Eight-bit symbols with read held high every cycle
    push(2, 8'h11);
    push(2, 8'h22);
    push(2, 8'h33);
    read[2] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      take = !empty[2];
      @(negedge clk);
      if (take && g < 8) begin
        got[g] = sample[2];
        g++;
      end
    end
    read[2] = 1'b0;
    check("t6_byte_count", g, 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t6_byte%0d", i), {24'd0, got[i]}, {24'd0, enc(exp6[i])});
    check("t6_in_read_count", rd_cnt[2], 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
